// File: rtl/rv_mem_arb.sv
// Arbiter sharing one single-port memory between a fetch port and a data port.
// Serves one access at a time and alternates grants when both ports request.
module rv_mem_arb #(
   parameter int DPWIDTH     = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req,
   input  logic [DPWIDTH-1:0] i_addr,
   output logic [DPWIDTH-1:0] i_rdata,
   output logic               i_ack,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [DPWIDTH-1:0] d_addr,
   input  logic [DPWIDTH-1:0] d_wdata,
   output logic [DPWIDTH-1:0] d_rdata,
   output logic               d_ack,
   output logic               mem_en,
   output logic               mem_rw,
   output logic [DPWIDTH-1:0] mem_addr,
   output logic [DPWIDTH-1:0] mem_wdata,
   input  logic [DPWIDTH-1:0] mem_rdata,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t     state;
   state_t     state_nxt;
   logic       last_grant;  // 1 = data port won the last grant
   logic       gnt_data;
   logic       rw_q;
   logic [3:0] cnt;
   logic       grant;
   logic       grant_data;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      grant_data = 1'b0;
      mem_en     = 1'b0;
      mem_rw     = 1'b0;
      i_ack      = 1'b0;
      d_ack      = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant      = 1'b1;
               // On conflict the port that lost last time wins
               grant_data = d_req && (!i_req || !last_grant);
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            mem_en = 1'b1;
            mem_rw = rw_q;
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            i_ack     = !gnt_data;
            d_ack     = gnt_data;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         gnt_data   <= 1'b0;
         rw_q       <= 1'b0;
         cnt        <= 4'd0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else if (grant) begin
         last_grant <= grant_data;
         gnt_data   <= grant_data;
         rw_q       <= grant_data & d_we;
         cnt        <= WAIT_LD;
         mem_addr   <= grant_data ? d_addr : i_addr;
         mem_wdata  <= d_wdata;
      end else if (state == ACCESS) begin
         if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else if (!rw_q) begin
            if (gnt_data) d_rdata <= mem_rdata;
            else          i_rdata <= mem_rdata;
         end
      end
   end

endmodule
